// File: rtl/booth_pp_stage_pkg.sv
// Shared constants and Booth select encoding for the 32x32 multiplier front end.
package booth_pp_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NPP  = XLEN / 2 + 1;
  localparam int unsigned PW   = 2 * XLEN;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_POS1 = 3'd1,
    BOOTH_POS2 = 3'd2,
    BOOTH_NEG1 = 3'd3,
    BOOTH_NEG2 = 3'd4
  } booth_sel_e;

  // Group bits are {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_sel_e booth_decode(input logic [2:0] grp);
    booth_sel_e sel;
    case (grp)
      3'b001, 3'b010: sel = BOOTH_POS1;
      3'b011:         sel = BOOTH_POS2;
      3'b100:         sel = BOOTH_NEG2;
      3'b101, 3'b110: sel = BOOTH_NEG1;
      default:        sel = BOOTH_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_pp_stage_if.sv
// Operand/column handshake bundle between the issue side, the PP stage and the tree array.
interface booth_pp_stage_if;
  import booth_pp_stage_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_signed;
  logic [XLEN-1:0]     in_a;
  logic [XLEN-1:0]     in_b;
  logic                out_valid;
  logic                out_ready;
  logic [PW*NPP-1:0]   out_col;
  logic [NPP-1:0]      out_neg;

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_col, out_neg
  );

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_col, out_neg
  );

endinterface

// File: rtl/booth_pp_stage_booth_sel.sv
// One radix-4 Booth partial-product row: select 0/+-A/+-2A, shift into place, invert if negative.
module booth_sel
  import booth_pp_stage_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  logic [2:0]    grp,
  input  logic [PW-1:0] a64,
  output logic [PW-1:0] pp,
  output logic          neg
);

  booth_sel_e    sel;
  logic [PW-1:0] mag;
  logic [PW-1:0] x;

  always_comb begin
    sel = booth_decode(grp);
    mag = '0;
    neg = 1'b0;
    case (sel)
      BOOTH_POS1: mag = a64;
      BOOTH_POS2: mag = a64 << 1;
      BOOTH_NEG1: begin mag = a64;      neg = 1'b1; end
      BOOTH_NEG2: begin mag = a64 << 1; neg = 1'b1; end
      default:    mag = '0;
    endcase
    x  = mag << SHIFT;
    // Full-width inversion; the +1 travels separately as neg at weight 2^0.
    pp = neg ? ~x : x;
  end

endmodule

// File: rtl/booth_pp_stage.sv
// Booth partial-product stage: operand register, 17 Booth rows, column transpose, PP register.
module booth_pp_stage
  import booth_pp_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  booth_pp_stage_if.slave   bus
);

  logic                      s1_valid;
  logic                      s1_signed;
  logic [XLEN-1:0]           s1_a;
  logic [XLEN-1:0]           s1_b;
  logic                      s2_valid;
  logic [PW*NPP-1:0]         s2_col;
  logic [NPP-1:0]            s2_neg;

  logic                      s2_adv;
  logic                      s1_adv;
  logic                      accept;
  logic                      s1_move;

  logic [PW-1:0]             a64;
  logic                      b_ext;
  logic [2*NPP:0]            b35;
  logic [NPP-1:0][PW-1:0]    pp;
  logic [NPP-1:0]            neg;
  logic [PW*NPP-1:0]         col;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign s1_move      = s1_valid && s2_adv;

  assign bus.out_valid = s2_valid;
  assign bus.out_col   = s2_col;
  assign bus.out_neg   = s2_neg;

  assign a64   = s1_signed ? {{XLEN{s1_a[XLEN-1]}}, s1_a} : {{XLEN{1'b0}}, s1_a};
  assign b_ext = s1_signed & s1_b[XLEN-1];
  // Bit 0 is b[-1]; group g then sits at b35[2g+2:2g].
  assign b35   = {b_ext, b_ext, s1_b, 1'b0};

  for (genvar g = 0; g < NPP; g++) begin : g_row
    booth_sel #(.SHIFT(2 * g)) u_sel (
      .grp (b35[2*g +: 3]),
      .a64 (a64),
      .pp  (pp[g]),
      .neg (neg[g])
    );
  end

  always_comb begin
    col = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      for (int unsigned j = 0; j < NPP; j++) begin
        col[i*NPP + j] = pp[j][i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_signed <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_col    <= '0;
      s2_neg    <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        s1_valid <= accept || (s1_valid && !s2_adv);
        if (s2_adv) s2_valid <= s1_valid;
      end
      if (accept) begin
        s1_signed <= bus.in_signed;
        s1_a      <= bus.in_a;
        s1_b      <= bus.in_b;
      end
      if (s1_move) begin
        s2_col <= col;
        s2_neg <= neg;
      end
    end
  end

endmodule

// File: tb/tb_booth_pp_stage.sv
// Directed/random bench for booth_pp_stage: column sums plus neg bits must equal the product.
module tb_booth_pp_stage;
  import booth_pp_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  booth_pp_stage_if bus();

  booth_pp_stage dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned  n_tests   = 0;
  int unsigned  n_fail    = 0;
  int unsigned  n_results = 0;
  int unsigned  stalls    = 0;
  logic [63:0]  q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] col_sum(input logic [PW*NPP-1:0] c, input logic [NPP-1:0] ng);
    logic [63:0] s = '0;
    for (int i = 0; i < PW; i++)
      for (int j = 0; j < NPP; j++)
        if (c[i*NPP + j]) s = s + (64'd1 << i);
    for (int j = 0; j < NPP; j++)
      if (ng[j]) s = s + 64'd1;
    return s;
  endfunction

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  always @(negedge clk) begin : mon
    logic [63:0] e;
    if (!rst) begin
      if (flush) q.delete();
      else if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check_eq("spurious_out", 64'(bus.out_valid), 64'd0);
        else begin
          e = q.pop_front();
          check_eq("result", col_sum(bus.out_col, bus.out_neg), e);
          n_results++;
        end
      end
    end
  end

  task automatic send(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    bit acc = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_signed = s;
    bus.in_a      = a;
    bus.in_b      = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(exp);
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) break;
      stalls++;
    end
    bus.in_valid = 1'b0;
    if (!acc) check_eq("accept_timeout", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    check_eq("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic fill_two();
    bus.out_ready = 1'b0;
    send(0, 32'd11, 32'd13, 64'd143);
    send(1, 32'hFFFF_FFFE, 32'd21, 64'hFFFF_FFFF_FFFF_FFD6);
    check_eq("fill_out_valid", 64'(bus.out_valid), 64'd1);
  endtask

  initial begin : timeout
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned r;
    bit s;
    logic [31:0] a, b;
    logic [PW*NPP-1:0] snap;

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_signed = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.out_ready = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_neg", 64'(bus.out_neg), 64'd0);
    check_eq("rst_out_col_zero", 64'(bus.out_col == '0), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;

    // 1: unsigned, with latency check
    send(0, 32'd3, 32'd5, 64'd15);
    check_eq("lat_cycle1", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("lat_cycle2", 64'(bus.out_valid), 64'd1);
    drain();
    send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    send(0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    // 2: signed
    send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    send(1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    send(1, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB);
    send(1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    drain();
    check_eq("directed_count", 64'(n_results), 64'd7);

    // 3: back-to-back random
    r = n_results; stalls = 0;
    for (int k = 0; k < 100; k++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      send(s, a, b, model(s, a, b));
    end
    check_eq("b2b_stalls", 64'(stalls), 64'd0);
    drain();
    check_eq("b2b_count", 64'(n_results - r), 64'd100);

    // 4: backpressure
    r = n_results;
    fill_two();
    snap = bus.out_col;
    bus.in_valid = 1'b1; bus.in_signed = 1'b0; bus.in_a = 32'd100; bus.in_b = 32'd200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("bp_col_stable", 64'(bus.out_col == snap), 64'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(0, 32'd100, 32'd200, 64'd20000);
    drain();
    check_eq("bp_count", 64'(n_results - r), 64'd3);

    // 5: flush with both stages full and an op offered
    fill_two();
    r = n_results;
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_signed = 1'b0; bus.in_a = 32'd5; bus.in_b = 32'd5;
    @(negedge clk);
    check_eq("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    check_eq("flush_out_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("flush_no_results", 64'(n_results - r), 64'd0);
    send(0, 32'd9, 32'd7, 64'd63);
    drain();
    check_eq("flush_after_count", 64'(n_results - r), 64'd1);

    // 6: async reset mid-operation
    fill_two();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("arst_out_neg", 64'(bus.out_neg), 64'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    r = n_results;
    send(0, 32'd2, 32'd2, 64'd4);
    drain();
    check_eq("arst_after_count", 64'(n_results - r), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
